// File: rtl/wf_tick_scheduler.sv
// rtl/wf_tick_scheduler.sv - multi-channel tick-driven one-shot/periodic timer with command port
module wf_tick_scheduler #(
    parameter int NCH = 4,
    parameter int CW  = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_ch,
    input  logic [1:0]     cmd_op,
    input  logic [CW-1:0]  cmd_data,
    output logic [NCH-1:0] ch_pulse,
    output logic [NCH-1:0] ch_busy,
    output logic           cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ONESHOT  = 2'd1,
        ST_PERIODIC = 2'd2
    } ch_state_t;

    localparam logic [1:0] OP_STOP       = 2'd0;
    localparam logic [1:0] OP_START_ONE  = 2'd1;
    localparam logic [1:0] OP_START_PER  = 2'd2;
    localparam logic [1:0] OP_SET_PERIOD = 2'd3;

    ch_state_t      state_q [NCH];
    ch_state_t      state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [CW-1:0]  per_q   [NCH];
    logic [CW-1:0]  per_d   [NCH];
    logic [NCH-1:0] pulse_d;
    logic [NCH-1:0] busy_d;
    logic           accept;
    logic           ch_in_range;

    assign accept      = cmd_valid && cmd_ready;
    assign ch_in_range = ({29'd0, cmd_ch} < 32'(NCH));

    // A command addressed to a channel wins over a coincident tick for that channel only.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            per_d[k]   = per_q[k];
            pulse_d[k] = 1'b0;
            if (accept && ch_in_range && (cmd_ch == 3'(k))) begin
                unique case (cmd_op)
                    OP_STOP: begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                    end
                    OP_START_ONE: begin
                        state_d[k] = ST_ONESHOT;
                        cnt_d[k]   = '0;
                    end
                    OP_START_PER: begin
                        state_d[k] = ST_PERIODIC;
                        cnt_d[k]   = '0;
                    end
                    OP_SET_PERIOD: per_d[k] = cmd_data;
                    default: ;
                endcase
            end else if ((state_q[k] != ST_IDLE) && tick) begin
                // >= rather than == so a period lowered below the count ends on the next tick.
                if (cnt_q[k] >= per_q[k]) begin
                    cnt_d[k]   = '0;
                    pulse_d[k] = 1'b1;
                    if (state_q[k] == ST_ONESHOT) begin
                        state_d[k] = ST_IDLE;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
            busy_d[k] = (state_d[k] != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
                per_q[k]   <= '0;
            end
            ch_pulse  <= '0;
            ch_busy   <= '0;
            cmd_err   <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                per_q[k]   <= per_d[k];
            end
            ch_pulse  <= pulse_d;
            ch_busy   <= busy_d;
            cmd_err   <= accept && !ch_in_range;
            cmd_ready <= !accept;
        end
    end

endmodule

// File: tb/tb_wf_tick_scheduler.sv
// tb/tb_wf_tick_scheduler.sv - directed and randomized checks of wf_tick_scheduler against a reference model
module tb_wf_tick_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           tick = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_ch = 3'd0;
    logic [1:0]     cmd_op = 2'd0;
    logic [CW-1:0]  cmd_data = '0;
    logic [NCH-1:0] ch_pulse;
    logic [NCH-1:0] ch_busy;
    logic           cmd_err;

    wf_tick_scheduler #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .ch_pulse(ch_pulse), .ch_busy(ch_busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 one-shot, 2 periodic; counts kept as plain integers.
    int m_mode [NCH];
    int m_cnt  [NCH];
    int m_per  [NCH];
    bit m_pulse [NCH];
    bit m_ready;
    bit m_err;
    bit m_acc;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NCH-1:0] ep, eb;
        for (int k = 0; k < NCH; k++) begin
            ep[k] = m_pulse[k];
            eb[k] = (m_mode[k] != 0);
        end
        checks++;
        assert (ch_pulse === ep) else begin
            errors++;
            $error("FAIL ch_pulse got %b expected %b at %0t", ch_pulse, ep, $time);
        end
        checks++;
        assert (ch_busy === eb) else begin
            errors++;
            $error("FAIL ch_busy got %b expected %b at %0t", ch_busy, eb, $time);
        end
        checks++;
        assert (cmd_err === m_err) else begin
            errors++;
            $error("FAIL cmd_err got %b expected %b at %0t", cmd_err, m_err, $time);
        end
        checks++;
        assert (cmd_ready === m_ready) else begin
            errors++;
            $error("FAIL cmd_ready got %b expected %b at %0t", cmd_ready, m_ready, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk);
        for (int k = 0; k < NCH; k++) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_per[k] = 0; m_pulse[k] = 1'b0;
        end
        m_ready = 1'b0;
        m_err = 1'b0;
        m_acc = 1'b0;
        #1 check_outputs();
        reset = 1'b0;
    endtask

    task automatic step(input bit t, input bit v, input int ch, input int op, input int d);
        tick = t;
        cmd_valid = v;
        cmd_ch = 3'(ch);
        cmd_op = 2'(op);
        cmd_data = CW'(d);
        @(posedge clk);
        m_acc = v && m_ready;
        for (int k = 0; k < NCH; k++) begin
            m_pulse[k] = 1'b0;
            if (m_acc && ch == k) begin
                case (op)
                    0: begin m_mode[k] = 0; m_cnt[k] = 0; end
                    1: begin m_mode[k] = 1; m_cnt[k] = 0; end
                    2: begin m_mode[k] = 2; m_cnt[k] = 0; end
                    default: m_per[k] = d;
                endcase
            end else if (m_mode[k] != 0 && t) begin
                if (m_cnt[k] >= m_per[k]) begin
                    m_cnt[k] = 0;
                    m_pulse[k] = 1'b1;
                    if (m_mode[k] == 1) m_mode[k] = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
        m_err = m_acc && (ch >= NCH);
        m_ready = !m_acc;
        #1 check_outputs();
    endtask

    task automatic cmd(input int ch, input int op, input int d);
        step(1'b0, 1'b1, ch, op, d);
        step(1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int cnt, cyc, idx, guard;
        int qch [4];
        int qop [4];
        int qd  [4];

        do_reset();
        step(1'b0, 1'b0, 0, 0, 0);
        chk("ready_after_reset", int'(cmd_ready), 1);

        // Periodic P=4 with tick every cycle: one pulse per 5 ticks.
        cmd(0, 3, 4);
        cmd(0, 2, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 0, 0, 0);
            cnt += int'(ch_pulse[0]);
        end
        chk("ch0_periodic_pulses", cnt, 4);
        chk("ch0_busy", int'(ch_busy[0]), 1);

        // One-shot P=2 with tick every third cycle: single pulse on the third tick.
        cmd(1, 3, 2);
        cmd(1, 1, 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(i % 3 == 2, 1'b0, 0, 0, 0);
            cnt += int'(ch_pulse[1]);
        end
        chk("ch1_oneshot_pulses", cnt, 1);
        chk("ch1_busy_after", int'(ch_busy[1]), 0);

        // Period lowered below the count terminates on the next tick.
        cmd(2, 3, 9);
        cmd(2, 2, 0);
        guard = 0;
        while (m_cnt[2] != 7 && guard < 20) begin
            step(1'b1, 1'b0, 0, 0, 0);
            guard++;
        end
        chk("ch2_reach_c7", m_cnt[2], 7);
        cmd(2, 3, 3);
        step(1'b1, 1'b0, 0, 0, 0);
        chk("ch2_early_pulse", int'(ch_pulse[2]), 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 0, 0, 0);
            cnt += int'(ch_pulse[2]);
        end
        chk("ch2_pulses_p3", cnt, 2);

        // STOP coinciding with ch0's terminal tick suppresses its pulse; ch3 unaffected.
        cmd(3, 3, 1);
        cmd(3, 2, 0);
        guard = 0;
        while (m_cnt[0] != 4 && guard < 10) begin
            step(1'b1, 1'b0, 0, 0, 0);
            guard++;
        end
        chk("ch0_at_terminal", m_cnt[0], 4);
        step(1'b1, 1'b1, 0, 0, 0);
        chk("ch0_stop_no_pulse", int'(ch_pulse[0]), 0);
        chk("ch0_stop_busy", int'(ch_busy[0]), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 0, 0, 0);
            cnt += int'(ch_pulse[3]);
        end
        chk("ch3_pulses", cnt, 3);

        // Back-to-back commands with valid held high; an out-of-range channel raises cmd_err.
        qch = '{1, 1, 5, 0};
        qop = '{3, 2, 2, 3};
        qd  = '{3, 0, 0, 6};
        idx = 0; cyc = 0; cnt = 0;
        while (idx < 4 && cyc < 20) begin
            step(1'b0, 1'b1, qch[idx], qop[idx], qd[idx]);
            if (m_acc) idx++;
            cyc++;
            cnt += int'(cmd_err);
        end
        step(1'b0, 1'b0, 0, 0, 0);
        cnt += int'(cmd_err);
        chk("b2b_cycles", cyc, 7);
        chk("cmd_err_count", cnt, 1);

        // Reset while all channels run: everything stops and stays quiet.
        cmd(0, 2, 0);
        cmd(2, 2, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 0, 0);
        chk("all_busy", int'(ch_busy), 15);
        do_reset();
        chk("reset_busy", int'(ch_busy), 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 0, 0, 0);
            if (i == 0) chk("ready_after_reset2", int'(cmd_ready), 1);
            cnt += int'(ch_pulse != '0);
        end
        chk("no_pulse_after_reset", cnt, 0);

        // Randomized traffic, including out-of-range channels and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'(($urandom_range(0, 99) < 60)), 1'(($urandom_range(0, 99) < 30)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 6)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wf_tick_scheduler.md
WF_TICK_SCHEDULER -- requirements
Module: wf_tick_scheduler

Interface
REQ-001 Parameter NCH, default 4, number of timer channels; legal range 1..8.
REQ-002 Parameter CW, default 10, width of the counter and period of each channel.
REQ-003 clk  input  1  main core clock; all logic is clocked on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  shared time-base enable; one count per cycle in which it is high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_ch  input  3  target channel index.
REQ-009 cmd_op  input  2  operation: 00 STOP, 01 START_ONESHOT, 10 START_PERIODIC, 11 SET_PERIOD.
REQ-010 cmd_data  input  CW  period value, used by SET_PERIOD only.
REQ-011 ch_pulse  output  NCH  one-clk completion pulse per channel.
REQ-012 ch_busy  output  NCH  channel is running (ONESHOT or PERIODIC).
REQ-013 cmd_err  output  1  one-clk pulse when a command addressed cmd_ch >= NCH.

Function
REQ-014 Each channel SHALL hold a period register P[CW-1:0], a counter C[CW-1:0] and a state IDLE, ONESHOT or PERIODIC.
REQ-015 Handshake: a command SHALL be accepted on a rising edge where cmd_valid && cmd_ready.
REQ-016 cmd_ready SHALL be low for exactly the one cycle following an accept and high otherwise (outside reset), so the maximum command rate is one per 2 cycles.
REQ-017 cmd_ch, cmd_op and cmd_data SHALL be sampled only at accept.
REQ-018 START_ONESHOT / START_PERIODIC SHALL set C=0 and the state to ONESHOT / PERIODIC, effective the cycle after accept; a start on a running channel restarts it.
REQ-019 STOP SHALL set the state to IDLE and C=0; STOP on an IDLE channel has no effect.
REQ-020 SET_PERIOD SHALL load P=cmd_data without changing the state or C.
REQ-021 A running channel with tick high and C < P SHALL increment C by 1.
REQ-022 A running channel with tick high and C >= P SHALL set C=0 and assert ch_pulse[ch] on the next cycle for exactly one clk.
REQ-023 On that terminal tick, ONESHOT SHALL go to IDLE and PERIODIC SHALL remain PERIODIC.
REQ-024 The pulse period SHALL be P+1 ticks, and P=0 SHALL pulse on every tick.
REQ-025 The >= compare SHALL ensure that a period lowered below C terminates on the next tick; C SHALL never wrap through 2^CW-1.
REQ-026 ch_pulse SHALL be one clk wide even when tick is held high continuously.
REQ-027 An IDLE channel SHALL ignore tick, hold C=0, and never pulse.
REQ-028 When a command to channel k is accepted in the same cycle as a tick, the command SHALL take precedence for channel k: that tick is ignored and no pulse is generated.
REQ-029 Other channels SHALL process the simultaneous tick normally.
REQ-030 A command with cmd_ch >= NCH SHALL be accepted, SHALL change no channel state, and SHALL pulse cmd_err the next cycle.
REQ-031 ch_busy[k] SHALL be high exactly while channel k is in ONESHOT or PERIODIC.
REQ-032 ch_busy SHALL drop in the same cycle that the final ONESHOT ch_pulse rises.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While reset is high, all channels SHALL be IDLE with C=0 and P=0, and ch_pulse=0, ch_busy=0, cmd_err=0, cmd_ready=0.
REQ-035 cmd_ready SHALL rise on the first cycle after reset deasserts.
REQ-036 Reset asserted mid-count SHALL abort all channels on that edge, with no pulse emitted then or afterwards.

Verification
REQ-037 SET_PERIOD ch0=4, START_PERIODIC ch0, tick every cycle -> ch_pulse[0] one clk wide every 5 cycles; ch_busy[0] stays high.
REQ-038 SET_PERIOD ch1=2, START_ONESHOT ch1, tick every 3rd cycle -> exactly one ch_pulse[1] after the 3rd tick; ch_busy[1] falls with it; no further pulses.
REQ-039 ch2 PERIODIC with P=9 and C=7; SET_PERIOD ch2=3 -> pulse on the next tick, then every 4 ticks.
REQ-040 STOP ch0 accepted in the same cycle as its terminal tick -> no pulse; ch_busy[0]=0; ch3 (periodic) pulses unaffected.
REQ-041 cmd_valid held high for 4 commands -> accepts on alternate cycles only; a command with cmd_ch=5 (NCH=4) -> cmd_err pulses once, no state change.
REQ-042 Reset asserted for 1 cycle while all 4 channels run -> all outputs 0, no pulse for 100 cycles of ticks, and cmd_ready=1 the cycle after reset.
